// File: rtl/multi_port_free_list_if.sv
// Rename-side view of the physical register free list: allocation, free,
// checkpoint restore and occupancy status.
interface multi_port_free_list_if #(
  parameter int DEPTH     = 32,
  parameter int PHYS_BITS = 6,
  parameter int DEQ_PORTS = 2,
  parameter int ENQ_PORTS = 2
);
  localparam int PTR = $clog2(DEPTH);
  localparam int CW  = $clog2(DEQ_PORTS + 1);

  logic [CW-1:0]                         deq_cnt;
  logic                                  deq_ok;
  logic [DEQ_PORTS-1:0][PHYS_BITS-1:0]   deq_preg;
  logic [DEQ_PORTS-1:0]                  deq_vld;
  logic [ENQ_PORTS-1:0]                  enq_vld;
  logic [ENQ_PORTS-1:0][PHYS_BITS-1:0]   enq_preg;
  logic                                  flush;
  logic [PTR:0]                          ckpt_head;
  logic [PTR:0]                          cur_head;
  logic [PTR:0]                          count;
  logic                                  empty;
  logic                                  full;
  logic                                  ovf_err;

  modport master (
    output deq_cnt, enq_vld, enq_preg, flush, ckpt_head,
    input  deq_ok, deq_preg, deq_vld, cur_head, count, empty, full, ovf_err
  );

  modport slave (
    input  deq_cnt, enq_vld, enq_preg, flush, ckpt_head,
    output deq_ok, deq_preg, deq_vld, cur_head, count, empty, full, ovf_err
  );
endinterface

// File: rtl/multi_port_free_list.sv
// Circular free list of physical register indices: multi-port allocate at
// the head, compacted multi-port free at the tail, head restore on flush.
module free_list_rd_lane #(
  parameter int DEPTH     = 32,
  parameter int PHYS_BITS = 6,
  parameter int LANE      = 0
) (
  input  logic [DEPTH-1:0][PHYS_BITS-1:0] data,
  input  logic [$clog2(DEPTH):0]          head,
  input  logic [$clog2(DEPTH):0]          count,
  output logic [PHYS_BITS-1:0]            preg,
  output logic                            vld
);
  localparam int PTR = $clog2(DEPTH);
  localparam logic [PTR-1:0] OFF    = PTR'(LANE);
  localparam logic [PTR:0]   LANE_P = (PTR+1)'(LANE);

  logic [PTR-1:0] idx;

  assign idx  = head[PTR-1:0] + OFF;
  assign preg = data[idx];
  assign vld  = count > LANE_P;
endmodule

module multi_port_free_list #(
  parameter int DEPTH     = 32,
  parameter int PHYS_BITS = 6,
  parameter int INIT_BASE = 32,
  parameter int DEQ_PORTS = 2,
  parameter int ENQ_PORTS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multi_port_free_list_if.slave   fl
);
  localparam int PTR = $clog2(DEPTH);
  localparam int PW  = PTR + 1;
  localparam logic [PTR:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PTR:0] ONE     = PW'(1);

  logic [DEPTH-1:0][PHYS_BITS-1:0]     data;
  logic [PTR:0]                        head, tail, count, req, grant, space, n_acc;
  logic                                deq_ok, ovf_err, ovf_now;
  logic [ENQ_PORTS-1:0]                wr_en;
  logic [ENQ_PORTS-1:0][PTR-1:0]       wr_idx;
  logic [DEQ_PORTS-1:0][PHYS_BITS-1:0] lane_preg;
  logic [DEQ_PORTS-1:0]                lane_vld;

  assign count  = tail - head;
  assign req    = PW'(fl.deq_cnt);
  assign deq_ok = count >= req;
  // Flush suppresses the head advance, so a flush cycle grants nothing.
  assign grant  = (deq_ok && !fl.flush) ? req : '0;
  assign space  = DEPTH_P - (count - grant);

  genvar k;
  generate
    for (k = 0; k < DEQ_PORTS; k++) begin : g_lane
      free_list_rd_lane #(
        .DEPTH     (DEPTH),
        .PHYS_BITS (PHYS_BITS),
        .LANE      (k)
      ) u_lane (
        .data  (data),
        .head  (head),
        .count (count),
        .preg  (lane_preg[k]),
        .vld   (lane_vld[k])
      );
    end
  endgenerate

  // Active frees pack into consecutive tail slots; late ports lose on overflow.
  always_comb begin
    n_acc   = '0;
    ovf_now = 1'b0;
    wr_en   = '0;
    wr_idx  = '0;
    for (int j = 0; j < ENQ_PORTS; j++) begin
      if (fl.enq_vld[j]) begin
        if (n_acc < space) begin
          wr_en[j]  = 1'b1;
          wr_idx[j] = tail[PTR-1:0] + n_acc[PTR-1:0];
          n_acc     = n_acc + ONE;
        end else begin
          ovf_now = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= DEPTH_P;
      ovf_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        data[i] <= PHYS_BITS'(INIT_BASE + i);
    end else begin
      head <= fl.flush ? fl.ckpt_head : head + grant;
      tail <= tail + n_acc;
      if (ovf_now) ovf_err <= 1'b1;
      for (int j = 0; j < ENQ_PORTS; j++)
        if (wr_en[j]) data[wr_idx[j]] <= fl.enq_preg[j];
    end
  end

  assign fl.deq_ok   = deq_ok;
  assign fl.deq_preg = lane_preg;
  assign fl.deq_vld  = lane_vld;
  assign fl.cur_head = head;
  assign fl.count    = count;
  assign fl.empty    = (count == '0);
  assign fl.full     = (count == DEPTH_P);
  assign fl.ovf_err  = ovf_err;
endmodule

// File: tb/tb_multi_port_free_list.sv
// Scoreboarded random + directed bench for multi_port_free_list against a
// queue-based free-list model.
module tb_multi_port_free_list;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_port_free_list_if fl_if ();

  multi_port_free_list dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fl    (fl_if)
  );

  typedef struct {
    int       count;
    bit       ok;
    bit [1:0] vld;
    int       preg0;
    int       preg1;
    bit       empty;
    bit       full;
    int       head;
    bit       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   q[$];       // free registers in allocation order
  int   recent[$];  // most recent allocations, newest last
  int   mhead;
  bit   movf;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int act, input int e);
    n_cmp++;
    if (act != e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
    recent.delete();
    mhead = 0;
    movf  = 1'b0;
  endtask

  task automatic idle_inputs();
    fl_if.deq_cnt   = '0;
    fl_if.enq_vld   = '0;
    fl_if.enq_preg  = '0;
    fl_if.flush     = 1'b0;
    fl_if.ckpt_head = '0;
  endtask

  // One cycle of stimulus: drive, record expected outputs, advance the model.
  task automatic cyc(input int dc, input bit [1:0] ev, input int p0, input int p1,
                     input bit fl, input int r);
    exp_t e;
    int size, grant, space, acc;
    int pv[2];
    @(posedge clk); #1;
    fl_if.deq_cnt     = 2'(dc);
    fl_if.enq_vld     = ev;
    fl_if.enq_preg[0] = 6'(p0);
    fl_if.enq_preg[1] = 6'(p1);
    fl_if.flush       = fl;
    fl_if.ckpt_head   = 6'((mhead - r) & 63);
    size    = q.size();
    e.count = size;
    e.ok    = (size >= dc);
    e.vld   = {size > 1, size > 0};
    e.preg0 = (size > 0) ? q[0] : 0;
    e.preg1 = (size > 1) ? q[1] : 0;
    e.empty = (size == 0);
    e.full  = (size == 32);
    e.head  = mhead;
    e.ovf   = movf;
    exp_q.push_back(e);
    grant = (e.ok && !fl) ? dc : 0;
    space = 32 - (size - grant);
    if (fl) begin
      for (int i = 0; i < r; i++) q.push_front(recent.pop_back());
      mhead = (mhead - r) & 63;
    end else begin
      for (int i = 0; i < grant; i++) recent.push_back(q.pop_front());
      mhead = (mhead + grant) & 63;
    end
    while (recent.size() > 32) void'(recent.pop_front());
    pv[0] = p0 & 63;
    pv[1] = p1 & 63;
    acc = 0;
    for (int j = 0; j < 2; j++) begin
      if (ev[j]) begin
        if (acc < space) begin
          q.push_back(pv[j]);
          acc++;
        end else begin
          movf = 1'b1;
        end
      end
    end
  endtask

  task automatic rnd();
    int dc, size, pop, r, maxr, grant;
    bit [1:0] ev;
    bit fl;
    dc   = int'($urandom_range(0, 2));
    ev   = 2'($urandom_range(0, 3));
    fl   = ($urandom_range(0, 7) == 0);
    size = q.size();
    pop  = int'(ev[0]) + int'(ev[1]);
    r    = 0;
    if (fl) begin
      if (size + pop > 32) begin ev = 2'b00; pop = 0; end
      maxr = 32 - size - pop;
      if (recent.size() < maxr) maxr = recent.size();
      r = int'($urandom_range(0, unsigned'(maxr)));
    end else begin
      grant = (size >= dc) ? dc : 0;
      if (size - grant + pop > 32) ev = 2'b00;
    end
    cyc(dc, ev, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), fl, r);
  endtask

  task automatic reset_check();
    @(negedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_count", int'(fl_if.count), 32);
    chk("rst_full", int'(fl_if.full), 1);
    chk("rst_empty", int'(fl_if.empty), 0);
    chk("rst_preg0", int'(fl_if.deq_preg[0]), 32);
    chk("rst_preg1", int'(fl_if.deq_preg[1]), 33);
    chk("rst_vld", int'(fl_if.deq_vld), 3);
    chk("rst_head", int'(fl_if.cur_head), 0);
    chk("rst_ovf", int'(fl_if.ovf_err), 0);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compare each cycle's outputs against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("count", int'(fl_if.count), e.count);
      chk("deq_ok", int'(fl_if.deq_ok), int'(e.ok));
      chk("deq_vld", int'(fl_if.deq_vld), int'(e.vld));
      if (e.vld[0]) chk("deq_preg0", int'(fl_if.deq_preg[0]), e.preg0);
      if (e.vld[1]) chk("deq_preg1", int'(fl_if.deq_preg[1]), e.preg1);
      chk("empty", int'(fl_if.empty), int'(e.empty));
      chk("full", int'(fl_if.full), int'(e.full));
      chk("cur_head", int'(fl_if.cur_head), e.head);
      chk("ovf_err", int'(fl_if.ovf_err), int'(e.ovf));
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    #12 rst_n = 1'b1;

    // Drain the whole list two at a time, then observe empty.
    for (int i = 0; i < 16; i++) cyc(2, 2'b00, 0, 0, 1'b0, 0);
    cyc(0, 2'b00, 0, 0, 1'b0, 0);

    // Stall with one entry, free into the stall cycle, then grant.
    cyc(0, 2'b01, 9, 0, 1'b0, 0);
    cyc(2, 2'b01, 5, 0, 1'b0, 0);
    cyc(2, 2'b00, 0, 0, 1'b0, 0);

    // Compaction of a lone port-1 free alongside a dual allocate.
    cyc(0, 2'b11, 20, 21, 1'b0, 0);
    cyc(0, 2'b11, 22, 23, 1'b0, 0);
    cyc(2, 2'b10, 0, 7, 1'b0, 0);
    cyc(0, 2'b00, 0, 0, 1'b0, 0);

    // Checkpoint, allocate six, restore with two frees in the flush cycle.
    for (int i = 0; i < 4; i++) cyc(0, 2'b11, 10 + 2*i, 11 + 2*i, 1'b0, 0);
    for (int i = 0; i < 3; i++) cyc(2, 2'b00, 0, 0, 1'b0, 0);
    cyc(2, 2'b11, 40, 41, 1'b1, 6);
    cyc(0, 2'b00, 0, 0, 1'b0, 0);

    // Mixed random traffic across several pointer wraps.
    for (int i = 0; i < 96; i++) rnd();

    // Fill, then free two more while full.
    while (q.size() < 31) cyc(0, 2'b11, 1, 2, 1'b0, 0);
    if (q.size() == 31) cyc(0, 2'b01, 3, 0, 1'b0, 0);
    cyc(0, 2'b11, 50, 51, 1'b0, 0);
    cyc(0, 2'b00, 0, 0, 1'b0, 0);
    cyc(1, 2'b00, 0, 0, 1'b0, 0);

    // Asynchronous reset mid-cycle, then confirm normal operation resumes.
    reset_check();
    cyc(2, 2'b00, 0, 0, 1'b0, 0);
    cyc(1, 2'b01, 12, 0, 1'b0, 0);
    cyc(0, 2'b00, 0, 0, 1'b0, 0);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multi_port_free_list.md
# multi_port_free_list

Physical-register free list for the superscalar rename stage: a circular FIFO of free physical register indices that hands out up to DEQ_PORTS registers per cycle to dispatch and accepts up to ENQ_PORTS freed registers per cycle from retirement. Supports single-cycle checkpoint restore of the head pointer on a pipeline flush. Sits between the RRAT/retirement path (producer) and dispatch/rename (consumer).

## Interface
- DEPTH, 32: number of entries; power of two, ≥ 4.
- PHYS_BITS, 6: physical register index width.
- INIT_BASE, 32: index of the first register loaded at reset; entry i resets to INIT_BASE+i. INIT_BASE+DEPTH−1 must fit in PHYS_BITS.
- DEQ_PORTS, 2: maximum allocations per cycle, 1..4.
- ENQ_PORTS, 2: maximum frees per cycle, 1..4.
- Derived: PTR = log2(DEPTH); pointers and count are PTR+1 bits.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- deq_cnt  in  clog2(DEQ_PORTS+1)  registers requested this cycle (0..DEQ_PORTS).
- deq_ok  out  1  count ≥ deq_cnt; request granted this cycle.
- deq_preg[k]  out  PHYS_BITS ×DEQ_PORTS  entry at head+k (combinational read).
- deq_vld[k]  out  1 ×DEQ_PORTS  count > k.
- enq_vld[j]  in  1 ×ENQ_PORTS  port j frees a register.
- enq_preg[j]  in  PHYS_BITS ×ENQ_PORTS  register freed on port j.
- flush  in  1  restore head from ckpt_head.
- ckpt_head  in  PTR+1  checkpointed head value.
- cur_head  out  PTR+1  current head, for checkpointing at branch dispatch.
- count  out  PTR+1  tail − head (free entries available).
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- ovf_err  out  1  sticky: an enqueue was dropped for lack of space.

## Operation
- Storage: DEPTH × PHYS_BITS array, head and tail pointers of PTR+1 bits; index = low PTR bits; wrap bit distinguishes full from empty.
- Reset (rst_n low, asynchronous): data[i] = INIT_BASE+i, head = 0, tail = DEPTH, ovf_err = 0. Outputs after reset: count = DEPTH, full = 1, empty = 0, cur_head = 0, deq_preg[k] = INIT_BASE+k, all deq_vld = 1 (DEQ_PORTS ≤ DEPTH).
- Dequeue: all-or-nothing. deq_ok = (count ≥ deq_cnt). If deq_ok and not flush, head += deq_cnt. If not deq_ok, head unchanged; dispatch stalls. deq_cnt = 0 always gives deq_ok = 1.
- Enqueue: active enq_vld ports are compacted in ascending port order; the n-th active port writes data[tail+n], tail += popcount(enq_vld). Holes in enq_vld are permitted.
- Overflow: if count − (granted deq) + popcount(enq_vld) would exceed DEPTH, the excess highest-numbered ports are dropped and ovf_err sets until reset. Legal operation never triggers this.
- No bypass: registers enqueued in cycle t become visible to deq_preg and count in cycle t+1. Dequeue in cycle t considers only pre-edge contents.
- Flush: head ← ckpt_head; deq_cnt ignored in that cycle (no head increment), deq_ok still driven. Enqueues in the flush cycle still complete (tail advances normally).
- Pointer arithmetic is modulo 2^(PTR+1); count = tail − head modulo 2^(PTR+1).

## Timing
- deq_preg, deq_vld, deq_ok, count, empty, full: combinational from registered state and deq_cnt; no input→output path except deq_cnt→deq_ok.
- Pointer, data and ovf_err updates: one rising edge after request.
- cur_head reflects the state before the current cycle's dequeue; a checkpoint taken in cycle t while dequeuing n registers must be cur_head+n (computed by dispatch).
- Back-to-back full-rate dequeue and enqueue sustained indefinitely, including across wrap-around of the physical index.

## Test plan
- Reset: assert rst_n low mid-cycle, release -> count = 32, full = 1, deq_preg[0] = 32, deq_preg[1] = 33, ovf_err = 0; state clears without a clock edge.
- Dual allocate: deq_cnt = 2 for 16 cycles -> deq_preg pairs 32/33 … 62/63, then count = 0, empty = 1, deq_vld = 0.
- Stall: count = 1, deq_cnt = 2 -> deq_ok = 0, head unchanged; next cycle with enq_vld = 01 (preg 5) -> count = 2, deq_ok = 1, deq_preg = {prior, 5}.
- Compaction and same-cycle: count = 4, deq_cnt = 2, enq_vld = 10 with preg 7 -> next cycle count = 3, 7 written at old tail, not visible in enqueue cycle.
- Flush: record cur_head = H, dequeue 6, flush with ckpt_head = H and enq_vld = 11 -> head = H, tail +2, count = previous count + 2.
- Wrap and overflow: run 3×DEPTH mixed cycles checking FIFO order against a model; then enqueue 2 while full -> count stays 32, ovf_err = 1.
